multicycle_control: RTL and testbench

//  Main control FSM of the multicycle CPU. Sequences fetch/decode/execute/memory/writeback.

---
 rtl/multicycle_control_pkg.sv | 60 ++++++
 rtl/multicycle_control_mem_wait_timer.sv | 49 ++++
 rtl/multicycle_control.sv | 196 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_control_pkg
// Shared definitions for the multicycle CPU control unit:
//   - state_e        : FSM state encodings (also exported on the debug port)
//   - OP_*           : primary opcodes (IR[31:26]) understood by the decoder
//   - alu_op_e       : ALU operation select driven into the ALU control
//   - alu_src_b_e    : ALU B-operand mux select
//   - pc_source_e    : PC next-value mux select
//   - is_mem_wait_state : states that sit on the memory ready handshake
// ---------------------------------------------------------------------------
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11
    } state_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'd0,
        SRCB_FOUR    = 2'd1,
        SRCB_IMM     = 2'd2,
        SRCB_IMM_SHL = 2'd3
    } alu_src_b_e;

    typedef enum logic [1:0] {
        PC_ALU    = 2'd0,
        PC_ALUOUT = 2'd1,
        PC_JUMP   = 2'd2
    } pc_source_e;

    // The three states that hold a memory request open until mem_ready.
    function automatic logic is_mem_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// ---------------------------------------------------------------------------
// multicycle_control_mem_wait_timer
// Counts how long the control FSM has been stalled on a memory handshake and
// flags when the count has reached TIMEOUT.
// Ports:
//   clk        in  sole clock, rising edge
//   reset      in  synchronous, active-high; clears the count
//   clear_i    in  FSM is leaving its state (or faulting); restart the count
//   wait_i     in  FSM is in a memory state and mem_ready is low
//   timeout_o  out count has reached TIMEOUT
// ---------------------------------------------------------------------------
module multicycle_control_mem_wait_timer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic wait_i,
    output logic timeout_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A state change always wins over a wait, so each memory state starts
    // its own budget from zero. The count never passes TIMEOUT because the
    // FSM faults (and therefore clears) once it gets there.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (wait_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Wait counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_o = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the multicycle CPU. Sequences fetch / decode / execute /
// memory / writeback and drives every datapath select and enable line.
// Memory states wait on mem_ready, guarded by a timeout watchdog.
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   opcode                     IR[31:26], valid from DECODE onward
//   mem_ready                  memory finished the current access this cycle
//   pc_write, pc_write_cond    PC load enables (conditional on zero^branch_sel)
//   branch_sel                 0=BEQ, 1=BNE polarity into the branch mux
//   pc_source                  0=ALU, 1=ALUOut, 2=jump target
//   iord, mem_read, mem_write  memory address select and request strobes
//   ir_write                   IR load enable
//   reg_dst, mem_to_reg        register file write address / data selects
//   reg_write                  register file write enable
//   alu_src_a, alu_src_b       ALU operand selects
//   alu_op                     0=add, 1=sub, 2=funct-decoded
//   illegal_op, mem_fault      one-cycle error pulses
//   state                      current state, for debug
// ---------------------------------------------------------------------------
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            branch_sel,
    output logic [1:0]      pc_source,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic            illegal_op,
    output logic            mem_fault,
    output logic [3:0]      state
);

    state_e state_q;
    state_e state_d;
    logic   memWaiting;
    logic   timedOut;
    logic   faultNow;
    logic   illegalNow;
    logic   timerClear;

    // A fault only fires while actually stalled; mem_ready arriving in the
    // timeout cycle itself lets the access complete normally.
    assign memWaiting = is_mem_wait_state(state_q) && !mem_ready;
    assign faultNow   = memWaiting && timedOut;
    assign timerClear = (state_d != state_q) || faultNow;

    multicycle_control_mem_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_mem_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (timerClear),
        .wait_i    (memWaiting),
        .timeout_o (timedOut)
    );

    // Next-state logic. Memory states either advance on mem_ready, abandon
    // the instruction on timeout, or hold. DECODE dispatches on the opcode
    // and flags anything it does not recognise.
    always_comb begin
        state_d    = state_q;
        illegalNow = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)     state_d = S_DECODE;
                else if (faultNow) state_d = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:    state_d = S_MEM_ADDR;
                    OP_R:            state_d = S_EXEC_R;
                    OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                    OP_J:            state_d = S_JUMP;
                    OP_ADDI:         state_d = S_ADDI_EX;
                    default: begin
                        state_d    = S_FETCH;
                        illegalNow = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready)     state_d = S_MEM_WB;
                else if (faultNow) state_d = S_FETCH;
            end
            S_MEM_WR: begin
                if (mem_ready)     state_d = S_FETCH;
                else if (faultNow) state_d = S_FETCH;
            end
            S_EXEC_R:  state_d = S_R_WB;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // State register; reset returns to FETCH from anywhere, including a
    // stalled memory state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Moore output decode. Only the FETCH PC/IR load follows mem_ready so the
    // instruction is captured exactly when memory delivers it.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_sel    = 1'b0;
        pc_source     = PC_ALU;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
            end
            S_DECODE: alu_src_b = SRCB_IMM_SHL;
            S_MEM_ADDR, S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PC_ALUOUT;
                branch_sel    = opcode[0];
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PC_JUMP;
            end
            S_ADDI_WB: reg_write = 1'b1;
            default: ;
        endcase
    end

    assign illegal_op = illegalNow;
    assign mem_fault  = faultNow;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2,
                           S_MEM_RD = 4'd3, S_MEM_WB = 4'd4, S_MEM_WR = 4'd5,
                           S_EXEC_R = 4'd6, S_R_WB = 4'd7, S_BRANCH = 4'd8,
                           S_JUMP = 4'd9, S_ADDI_EX = 4'd10, S_ADDI_WB = 4'd11;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       memReady;
    logic       pcWrite, pcWriteCond, branchSel, iord, memRead, memWrite, irWrite;
    logic       regDst, memToReg, regWrite, aluSrcA, illegalOp, memFault;
    logic [1:0] pcSource, aluSrcB, aluOp;
    logic [3:0] stateDbg;
    logic [21:0] observed;

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        mr;
        logic        chk;
        logic [21:0] exp;
    } step_t;

    step_t sb[$];

    multicycle_control dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .mem_ready     (memReady),
        .pc_write      (pcWrite),
        .pc_write_cond (pcWriteCond),
        .branch_sel    (branchSel),
        .pc_source     (pcSource),
        .iord          (iord),
        .mem_read      (memRead),
        .mem_write     (memWrite),
        .ir_write      (irWrite),
        .reg_dst       (regDst),
        .mem_to_reg    (memToReg),
        .reg_write     (regWrite),
        .alu_src_a     (aluSrcA),
        .alu_src_b     (aluSrcB),
        .alu_op        (aluOp),
        .illegal_op    (illegalOp),
        .mem_fault     (memFault),
        .state         (stateDbg)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Every output packed into one vector so a whole cycle compares at once.
    assign observed = {stateDbg, pcWrite, pcWriteCond, branchSel, pcSource, iord,
                       memRead, memWrite, irWrite, regDst, memToReg, regWrite,
                       aluSrcA, aluSrcB, aluOp, illegalOp, memFault};

    // Expected output vector for a state, written out from the control table.
    function automatic logic [21:0] expVec(input logic [3:0] st, input logic mr,
                                           input logic bs, input logic ill, input logic flt);
        logic pcw, pcwc, bsel, io, mrd, mwr, irw, rdst, m2r, rw, asa;
        logic [1:0] pcs, asb, aop;
        {pcw, pcwc, bsel, io, mrd, mwr, irw, rdst, m2r, rw, asa} = '0;
        pcs = 2'd0; asb = 2'd0; aop = 2'd0;
        case (st)
            S_FETCH:    begin mrd = 1; asb = 2'd1; pcw = mr; irw = mr; end
            S_DECODE:   asb = 2'd3;
            S_MEM_ADDR: begin asa = 1; asb = 2'd2; end
            S_MEM_RD:   begin mrd = 1; io = 1; end
            S_MEM_WB:   begin rw = 1; m2r = 1; end
            S_MEM_WR:   begin mwr = 1; io = 1; end
            S_EXEC_R:   begin asa = 1; aop = 2'd2; end
            S_R_WB:     begin rw = 1; rdst = 1; end
            S_BRANCH:   begin asa = 1; aop = 2'd1; pcwc = 1; pcs = 2'd1; bsel = bs; end
            S_JUMP:     begin pcw = 1; pcs = 2'd2; end
            S_ADDI_EX:  begin asa = 1; asb = 2'd2; end
            S_ADDI_WB:  rw = 1;
            default: ;
        endcase
        return {st, pcw, pcwc, bsel, pcs, io, mrd, mwr, irw, rdst, m2r, rw,
                asa, asb, aop, ill, flt};
    endfunction

    // Drive one cycle's worth of inputs.
    task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic mr);
        reset    = rst;
        opcode   = op;
        memReady = mr;
    endtask

    // Queue one cycle of stimulus together with the outputs it must produce.
    task automatic pushStep(input logic rst, input logic [5:0] op, input logic mr,
                            input logic chk, input logic [3:0] st, input logic bs,
                            input logic ill, input logic flt);
        step_t s;
        s.rst = rst; s.op = op; s.mr = mr; s.chk = chk;
        s.exp = expVec(st, mr, bs, ill, flt);
        sb.push_back(s);
    endtask

    // Reset release, then a reset landing in the middle of a stalled load.
    task automatic test_reset();
        step_t s;
        int idx = 0;
        pushStep(1, 6'h00, 0, 0, S_FETCH, 0, 0, 0);
        pushStep(1, 6'h00, 0, 0, S_FETCH, 0, 0, 0);
        pushStep(0, 6'h00, 0, 1, S_FETCH, 0, 0, 0);
        pushStep(0, 6'h23, 1, 1, S_FETCH, 0, 0, 0);
        pushStep(0, 6'h23, 1, 1, S_DECODE, 0, 0, 0);
        pushStep(0, 6'h23, 1, 1, S_MEM_ADDR, 0, 0, 0);
        for (int i = 0; i < 3; i++) pushStep(0, 6'h23, 0, 1, S_MEM_RD, 0, 0, 0);
        pushStep(1, 6'h23, 0, 1, S_MEM_RD, 0, 0, 0);
        pushStep(0, 6'h23, 0, 1, S_FETCH, 0, 0, 0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            applyStimulus(s.rst, s.op, s.mr);
            @(negedge clk);
            if (s.chk) begin
                nCompared++;
                if (observed !== s.exp) begin
                    nMismatched++;
                    $display("[TB] FAIL reset step %0d: got %h want %h", idx, observed, s.exp);
                end
            end
            idx++;
            @(posedge clk); #1;
        end
    endtask

    // Load word with memory always ready: five states, one register write.
    task automatic test_lw();
        step_t s;
        int idx = 0;
        pushStep(0, 6'h23, 1, 1, S_FETCH, 0, 0, 0);
        pushStep(0, 6'h23, 1, 1, S_DECODE, 0, 0, 0);
        pushStep(0, 6'h23, 1, 1, S_MEM_ADDR, 0, 0, 0);
        pushStep(0, 6'h23, 1, 1, S_MEM_RD, 0, 0, 0);
        pushStep(0, 6'h23, 1, 1, S_MEM_WB, 0, 0, 0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            applyStimulus(s.rst, s.op, s.mr);
            @(negedge clk);
            nCompared++;
            if (observed !== s.exp) begin
                nMismatched++;
                $display("[TB] FAIL lw step %0d: got %h want %h", idx, observed, s.exp);
            end
            idx++;
            @(posedge clk); #1;
        end
    endtask

    // BNE then BEQ: branch polarity follows opcode bit 0.
    task automatic test_branch();
        step_t s;
        int idx = 0;
        pushStep(0, 6'h05, 1, 1, S_FETCH, 0, 0, 0);
        pushStep(0, 6'h05, 1, 1, S_DECODE, 0, 0, 0);
        pushStep(0, 6'h05, 1, 1, S_BRANCH, 1, 0, 0);
        pushStep(0, 6'h04, 1, 1, S_FETCH, 0, 0, 0);
        pushStep(0, 6'h04, 1, 1, S_DECODE, 0, 0, 0);
        pushStep(0, 6'h04, 1, 1, S_BRANCH, 0, 0, 0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            applyStimulus(s.rst, s.op, s.mr);
            @(negedge clk);
            nCompared++;
            if (observed !== s.exp) begin
                nMismatched++;
                $display("[TB] FAIL branch step %0d: got %h want %h", idx, observed, s.exp);
            end
            idx++;
            @(posedge clk); #1;
        end
    endtask

    // Unknown opcode: illegal pulse in DECODE, straight back to FETCH.
    task automatic test_illegal();
        step_t s;
        int idx = 0;
        pushStep(0, 6'h3F, 1, 1, S_FETCH, 0, 0, 0);
        pushStep(0, 6'h3F, 1, 1, S_DECODE, 0, 1, 0);
        pushStep(0, 6'h3F, 0, 1, S_FETCH, 0, 0, 0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            applyStimulus(s.rst, s.op, s.mr);
            @(negedge clk);
            nCompared++;
            if (observed !== s.exp) begin
                nMismatched++;
                $display("[TB] FAIL illegal step %0d: got %h want %h", idx, observed, s.exp);
            end
            idx++;
            @(posedge clk); #1;
        end
    endtask

    // Store that never completes faults on its 16th cycle; a second store
    // whose ready arrives on that same cycle completes without a fault.
    task automatic test_sw_timeout();
        step_t s;
        int idx = 0;
        for (int r = 0; r < 2; r++) begin
            pushStep(0, 6'h2B, 1, 1, S_FETCH, 0, 0, 0);
            pushStep(0, 6'h2B, 1, 1, S_DECODE, 0, 0, 0);
            pushStep(0, 6'h2B, 1, 1, S_MEM_ADDR, 0, 0, 0);
            for (int i = 0; i < 15; i++) pushStep(0, 6'h2B, 0, 1, S_MEM_WR, 0, 0, 0);
            if (r == 0) pushStep(0, 6'h2B, 0, 1, S_MEM_WR, 0, 0, 1);
            else        pushStep(0, 6'h2B, 1, 1, S_MEM_WR, 0, 0, 0);
        end
        while (sb.size() > 0) begin
            s = sb.pop_front();
            applyStimulus(s.rst, s.op, s.mr);
            @(negedge clk);
            nCompared++;
            if (observed !== s.exp) begin
                nMismatched++;
                $display("[TB] FAIL sw_timeout step %0d: got %h want %h", idx, observed, s.exp);
            end
            idx++;
            @(posedge clk); #1;
        end
    endtask

    // Stalled fetch, then ADDI/J/R back to back, then a fetch timeout that
    // must restart the watchdog even though the state stays FETCH.
    task automatic test_back_to_back();
        step_t s;
        int idx = 0;
        for (int i = 0; i < 3; i++) pushStep(0, 6'h08, 0, 1, S_FETCH, 0, 0, 0);
        pushStep(0, 6'h08, 1, 1, S_FETCH, 0, 0, 0);
        pushStep(0, 6'h08, 1, 1, S_DECODE, 0, 0, 0);
        pushStep(0, 6'h08, 1, 1, S_ADDI_EX, 0, 0, 0);
        pushStep(0, 6'h08, 1, 1, S_ADDI_WB, 0, 0, 0);
        pushStep(0, 6'h02, 1, 1, S_FETCH, 0, 0, 0);
        pushStep(0, 6'h02, 1, 1, S_DECODE, 0, 0, 0);
        pushStep(0, 6'h02, 1, 1, S_JUMP, 0, 0, 0);
        pushStep(0, 6'h00, 1, 1, S_FETCH, 0, 0, 0);
        pushStep(0, 6'h00, 1, 1, S_DECODE, 0, 0, 0);
        pushStep(0, 6'h00, 1, 1, S_EXEC_R, 0, 0, 0);
        pushStep(0, 6'h00, 1, 1, S_R_WB, 0, 0, 0);
        for (int i = 0; i < 15; i++) pushStep(0, 6'h00, 0, 1, S_FETCH, 0, 0, 0);
        pushStep(0, 6'h00, 0, 1, S_FETCH, 0, 0, 1);
        pushStep(0, 6'h00, 0, 1, S_FETCH, 0, 0, 0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            applyStimulus(s.rst, s.op, s.mr);
            @(negedge clk);
            nCompared++;
            if (observed !== s.exp) begin
                nMismatched++;
                $display("[TB] FAIL back_to_back step %0d: got %h want %h", idx, observed, s.exp);
            end
            idx++;
            @(posedge clk); #1;
        end
    endtask

    // Test sequence.
    initial begin
        applyStimulus(1, 6'h00, 0);
        @(posedge clk); #1;
        test_reset();
        test_lw();
        test_branch();
        test_illegal();
        test_sw_timeout();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
